// File: rtl/dbus_arbiter_pkg.sv
// Shared types and size encodings for the ibus/dbus memory-port arbiter.
// Used by dbus_arbiter, its interface and the optional alignment checker.
package dbus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IBUS,
        OWN_DBUS
    } arb_owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // The reserved encoding 2'b11 behaves as a word access everywhere.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] sz;
        sz = norm_size(size);
        case (sz)
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return (addr_lo != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bus bundle around dbus_arbiter: fetch bus, data bus and the shared memory port.
// dbus_adel/dbus_ades exist only when DBUS_ALIGN_CHK_EN is defined.
interface dbus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          ibus_en;
    logic [AW-1:0] ibus_addr;
    logic [DW-1:0] ibus_rdata;
    logic          ibus_done;

    logic          dbus_en;
    logic          dbus_we;
    logic [1:0]    dbus_size;
    logic [AW-1:0] dbus_addr;
    logic [DW-1:0] dbus_wdata;
    logic [DW-1:0] dbus_rdata;
    logic          dbus_done;
`ifdef DBUS_ALIGN_CHK_EN
    logic          dbus_adel;
    logic          dbus_ades;
`endif

    logic          mem_req;
    logic          mem_we;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok;
    logic          mem_data_ok;
    logic [DW-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
`ifdef DBUS_ALIGN_CHK_EN
        output dbus_adel, dbus_ades,
`endif
        input  ibus_en, ibus_addr,
        output ibus_rdata, ibus_done,
        input  dbus_en, dbus_we, dbus_size, dbus_addr, dbus_wdata,
        output dbus_rdata, dbus_done,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    // Requesters plus memory side.
    modport master (
`ifdef DBUS_ALIGN_CHK_EN
        input  dbus_adel, dbus_ades,
`endif
        output ibus_en, ibus_addr,
        input  ibus_rdata, ibus_done,
        output dbus_en, dbus_we, dbus_size, dbus_addr, dbus_wdata,
        input  dbus_rdata, dbus_done,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/dbus_align_chk.sv
// Flags a dbus access whose address is not aligned to its size.
// Purely combinational, zero latency, no backpressure.
module dbus_align_chk
    import dbus_arbiter_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);
    assign misaligned = is_misaligned(size, addr_lo);
endmodule

// File: rtl/dbus_arbiter.sv
// Shares one single-outstanding memory port between ibus and dbus (dbus has priority).
// Latency: done 1 cycle after mem_data_ok, minimum 2 cycles after en; requesters stall by holding en.
// DBUS_ALIGN_CHK_EN: misaligned dbus requests are not issued and complete with dbus_adel/dbus_ades.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dbus_arbiter_if.slave bus
);

    arb_state_t    state_q, state_d;
    arb_owner_t    owner_q, owner_d;

    logic          req_we_q;
    logic [1:0]    req_size_q;
    logic [AW-1:0] req_addr_q;
    logic [DW-1:0] req_wdata_q;

    logic          ibus_done_q, dbus_done_q;
    logic [DW-1:0] ibus_rdata_q, dbus_rdata_q;

    logic          grant_d, grant_i, complete, dbus_exc, misaligned;

`ifdef DBUS_ALIGN_CHK_EN
    dbus_align_chk u_align_chk (
        .size       (bus.dbus_size),
        .addr_lo    (bus.dbus_addr[1:0]),
        .misaligned (misaligned)
    );
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        complete = 1'b0;
        dbus_exc = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (bus.dbus_en) begin
                    // A rejected dbus access still takes its turn so ibus cannot slip in.
                    if (misaligned) begin
                        dbus_exc = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                        owner_d = OWN_DBUS;
                        state_d = ARB_REQ;
                    end
                end else if (bus.ibus_en) begin
                    grant_i = 1'b1;
                    owner_d = OWN_IBUS;
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (bus.mem_addr_ok) begin
                    if (bus.mem_data_ok) begin
                        complete = 1'b1;
                        owner_d  = OWN_NONE;
                        state_d  = ARB_IDLE;
                    end else begin
                        state_d = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                if (bus.mem_data_ok) begin
                    complete = 1'b1;
                    owner_d  = OWN_NONE;
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_q     <= 1'b0;
            req_size_q   <= SIZE_BYTE;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            ibus_done_q  <= 1'b0;
            dbus_done_q  <= 1'b0;
            ibus_rdata_q <= '0;
            dbus_rdata_q <= '0;
        end else begin
            if (grant_d) begin
                req_we_q    <= bus.dbus_we;
                req_size_q  <= norm_size(bus.dbus_size);
                req_addr_q  <= bus.dbus_addr;
                req_wdata_q <= bus.dbus_wdata;
            end else if (grant_i) begin
                req_we_q    <= 1'b0;
                req_size_q  <= SIZE_WORD;
                req_addr_q  <= bus.ibus_addr;
                req_wdata_q <= '0;
            end
            ibus_done_q <= complete && (owner_q == OWN_IBUS);
            dbus_done_q <= (complete && (owner_q == OWN_DBUS)) || dbus_exc;
            if (complete && (owner_q == OWN_IBUS)) ibus_rdata_q <= bus.mem_rdata;
            if (complete && (owner_q == OWN_DBUS)) dbus_rdata_q <= bus.mem_rdata;
        end
    end

`ifdef DBUS_ALIGN_CHK_EN
    logic adel_q, ades_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adel_q <= 1'b0;
            ades_q <= 1'b0;
        end else begin
            adel_q <= dbus_exc && !bus.dbus_we;
            ades_q <= dbus_exc && bus.dbus_we;
        end
    end

    assign bus.dbus_adel = adel_q;
    assign bus.dbus_ades = ades_q;
`endif

    assign bus.mem_req    = (state_q == ARB_REQ);
    assign bus.mem_we     = req_we_q;
    assign bus.mem_size   = req_size_q;
    assign bus.mem_addr   = req_addr_q;
    assign bus.mem_wdata  = req_wdata_q;
    assign bus.ibus_done  = ibus_done_q;
    assign bus.ibus_rdata = ibus_rdata_q;
    assign bus.dbus_done  = dbus_done_q;
    assign bus.dbus_rdata = dbus_rdata_q;

endmodule
